// File: rtl/ks10_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ks10_prefetch_queue : sequential instruction prefetch FIFO feeding the IR |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ks10_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_load,
  input  logic [0:AW-1] pc_in,
  output logic          mem_req,
  output logic [0:AW-1] mem_addr,
  input  logic          mem_ack,
  input  logic [0:35]   mem_data,
  output logic          ir_valid,
  input  logic          ir_take,
  output logic [0:35]   ir_word,
  output logic [0:AW-1] ir_addr,
  output logic [0:4]    count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [0:4]    DEPTH_C = 5'(DEPTH);
  localparam logic [0:AW-1] ONE     = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        state_q, state_d;
  logic [0:AW-1] fa_q, fa_d;
  logic [0:AW-1] mem_addr_q, mem_addr_d;
  logic          mem_req_q, mem_req_d;
  logic [0:4]    count_q, count_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;

  logic [0:35]   word_mem [DEPTH];
  logic [0:AW-1] addr_mem [DEPTH];

  logic          pop, push;
  logic [0:4]    count_pop, count_new;

  assign pop       = (count_q != 5'd0) && ir_take;
  assign push      = (state_q == S_REQ) && mem_ack && !pc_load;
  assign count_pop = count_q - {4'b0, pop};
  assign count_new = count_pop + {4'b0, push};

  always_comb begin
    state_d    = state_q;
    fa_d       = fa_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    count_d    = count_new;
    rd_d       = rd_q + PW'(pop);
    wr_d       = wr_q + PW'(push);

    if (pc_load) begin
      count_d = 5'd0;
      rd_d    = '0;
      wr_d    = '0;
    end

    case (state_q)
      S_IDLE: begin
        // A redirect empties the queue, so it can issue straight to pc_in.
        if (pc_load) begin
          fa_d       = pc_in;
          mem_addr_d = pc_in;
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end else if (count_pop < DEPTH_C) begin
          mem_addr_d = fa_q;
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack && pc_load) begin
          fa_d      = pc_in;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else if (mem_ack) begin
          fa_d = fa_q + ONE;
          if (count_new < DEPTH_C) begin
            mem_addr_d = fa_q + ONE;
          end else begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end else if (pc_load) begin
          fa_d    = pc_in;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        // The stale request stays on the bus until acked; only fa follows redirects.
        if (pc_load) fa_d = pc_in;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fa_q       <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      count_q    <= 5'd0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fa_q       <= fa_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      word_mem[wr_q] <= mem_data;
      addr_mem[wr_q] <= fa_q;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_valid = (count_q != 5'd0);
  assign ir_word  = word_mem[rd_q];
  assign ir_addr  = addr_mem[rd_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ks10_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ks10_prefetch_queue : directed + random bench with transaction model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ks10_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 18;

  logic          clk = 1'b0;
  logic          rst, pc_load, mem_ack, ir_take;
  logic [0:AW-1] pc_in;
  logic [0:35]   mem_data;
  logic          mem_req, ir_valid;
  logic [0:AW-1] mem_addr, ir_addr;
  logic [0:35]   ir_word;
  logic [0:4]    count;

  always #5 clk = ~clk;

  ks10_prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ir_valid(ir_valid), .ir_take(ir_take), .ir_word(ir_word), .ir_addr(ir_addr),
    .count(count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  // Transaction-level reference: queued entries, fetch address, one outstanding read.
  typedef struct packed {logic [35:0] w; logic [17:0] a;} ent_t;
  ent_t        mq[$];
  logic [17:0] m_fa    = '0;
  logic [17:0] m_oaddr = '0;
  bit          m_out   = 1'b0;
  bit          m_disc  = 1'b0;

  task automatic model_update();
    bit pop, acked;
    if (!rst) begin
      mq.delete(); m_fa = '0; m_out = 1'b0; m_disc = 1'b0;
    end else begin
      pop   = (mq.size() != 0) && ir_take;
      acked = m_out && mem_ack;
      if (pc_load) begin
        mq.delete();
        m_fa = pc_in;
        if (!m_out) begin
          m_out = 1'b1; m_oaddr = pc_in; m_disc = 1'b0;
        end else if (acked) begin
          m_out = 1'b0; m_disc = 1'b0;
        end else begin
          m_disc = 1'b1;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (!m_out) begin
          if (mq.size() < DEPTH) begin m_out = 1'b1; m_oaddr = m_fa; end
        end else if (acked) begin
          if (m_disc) begin
            m_out = 1'b0; m_disc = 1'b0;
          end else begin
            mq.push_back('{w: mem_data, a: m_oaddr});
            m_fa = m_oaddr + 18'd1;
            if (mq.size() < DEPTH) m_oaddr = m_fa;
            else m_out = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    chk("mem_req", 64'(mem_req), 64'(m_out));
    if (m_out) chk("mem_addr", 64'(mem_addr), 64'(m_oaddr));
    chk("ir_valid", 64'(ir_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("ir_word", 64'(ir_word), 64'(mq[0].w));
      chk("ir_addr", 64'(ir_addr), 64'(mq[0].a));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    model_check();
  endtask

  initial begin
    rst = 1'b0; pc_load = 1'b0; pc_in = '0; mem_ack = 1'b0; ir_take = 1'b0; mem_data = '0;
    step(); step();
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_valid", 64'(ir_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    // First fetch after redirect
    rst = 1'b1; pc_load = 1'b1; pc_in = 18'o001000;
    step();
    chk("t1_req", 64'(mem_req), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'o001000);
    pc_load = 1'b0; mem_ack = 1'b1; mem_data = 36'o201040_000123;
    step();
    chk("t1_valid", 64'(ir_valid), 64'd1);
    chk("t1_opcode", 64'(ir_word[0:8]), 64'o201);
    chk("t1_ac", 64'(ir_word[9:12]), 64'o01);
    chk("t1_iraddr", 64'(ir_addr), 64'o001000);
    chk("t1_next", 64'(mem_addr), 64'o001001);

    // Redirect while 001002 is outstanding; its data must vanish
    mem_data = {4'($urandom()), $urandom()};
    step();
    mem_ack = 1'b0;
    step();
    pc_load = 1'b1; pc_in = 18'o002000;
    step();
    pc_load = 1'b0;
    step(); step();
    chk("t3_hold", 64'(mem_addr), 64'o001002);
    chk("t3_flushed", 64'(count), 64'd0);
    mem_ack = 1'b1; mem_data = 36'o777777_777777;
    step();
    chk("t3_drop", 64'(count), 64'd0);
    step();
    chk("t3_redir", 64'(mem_addr), 64'o002000);

    // Fill to DEPTH, then one pop resumes fetching
    for (int i = 0; i < DEPTH; i++) begin
      mem_data = {4'($urandom()), $urandom()};
      step();
    end
    chk("t2_full", 64'(count), 64'(DEPTH));
    chk("t2_noreq", 64'(mem_req), 64'd0);
    chk("t2_head", 64'(ir_addr), 64'o002000);
    step();
    chk("t2_stillfull", 64'(mem_req), 64'd0);
    mem_ack = 1'b0; ir_take = 1'b1;
    step();
    ir_take = 1'b0;
    chk("t2_resume", 64'(mem_req), 64'd1);
    chk("t2_addr", 64'(mem_addr), 64'o002004);

    // Redirect coincident with ack
    pc_load = 1'b1; pc_in = 18'o003000; mem_ack = 1'b1;
    step();
    chk("t4_count", 64'(count), 64'd0);
    pc_load = 1'b0; mem_ack = 1'b0;
    step();
    chk("t4_addr", 64'(mem_addr), 64'o003000);

    // Address wrap
    rst = 1'b0;
    step();
    rst = 1'b1; pc_load = 1'b1; pc_in = 18'o777777;
    step();
    pc_load = 1'b0; mem_ack = 1'b1;
    step();
    chk("t5_iraddr", 64'(ir_addr), 64'o777777);
    chk("t5_wrap", 64'(mem_addr), 64'o000000);

    // Reset mid-request with three entries, then a late ack
    step(); step();
    chk("t6_count3", 64'(count), 64'd3);
    mem_ack = 1'b0; rst = 1'b0;
    step();
    chk("t6_req", 64'(mem_req), 64'd0);
    chk("t6_valid", 64'(ir_valid), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    rst = 1'b1; mem_ack = 1'b1;
    step();
    chk("t6_late", 64'(count), 64'd0);
    mem_ack = 1'b0;
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      pc_load  = ($urandom_range(0, 15) == 0);
      pc_in    = ($urandom_range(0, 7) == 0) ? 18'o777776 : 18'($urandom());
      mem_ack  = ($urandom_range(0, 2) != 0);
      ir_take  = ($urandom_range(0, 2) == 0);
      mem_data = {4'($urandom()), $urandom()};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ks10_prefetch_queue.md
Name: ks10_prefetch_queue

Overview:
- Instruction prefetch queue directly upstream of the Instruction Register.
- Fetches sequential 36-bit instruction words from the memory interface into a small FIFO, tagged with their 18-bit address.
- Presents the head word on the bus that the IR latches, one word per IR clock-enable.
- A PC load (jump, trap, interrupt) flushes the queue and redirects fetching; a request already in flight is drained and its data discarded.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- AW, 18, fetch address width (bits [0:AW-1], big-endian numbering as elsewhere in the CPU).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- pc_load  input  1  redirect fetch: flush queue, new fetch address = pc_in.
- pc_in  input  [0:AW-1]  redirect address.
- mem_req  output  1  memory read request.
- mem_addr  output  [0:AW-1]  read address; stable while mem_req is high.
- mem_ack  input  1  read complete; mem_data valid this cycle. Only meaningful while mem_req is high.
- mem_data  input  [0:35]  read data.
- ir_valid  output  1  head entry present.
- ir_take  input  1  IR clock-enable; pops the head when ir_valid is high.
- ir_word  output  [0:35]  head instruction word; bits [0:8] opcode, [9:12] AC.
- ir_addr  output  [0:AW-1]  address of the head word.
- count  output  [0:4]  current number of entries, for debug.

Behaviour:
- Reset (rst == 0 at posedge): count = 0, read/write pointers = 0, fetch address fa = 0, mem_req = 0, state = IDLE, ir_valid = 0. ir_word/ir_addr are don't-care while ir_valid = 0. Reset overrides pc_load and mem_ack in the same cycle; an in-flight request is abandoned.
- Storage: DEPTH x (36 + AW) registers. ir_word/ir_addr are driven combinationally from the head entry; ir_valid = (count != 0).
- State machine:
  - IDLE: when count < DEPTH and pc_load = 0 → drive mem_req = 1, mem_addr = fa; go to REQ. mem_req rises the cycle after the decision, i.e. registered.
  - REQ: hold mem_req and mem_addr until mem_ack.
    - On mem_ack without pc_load: push {mem_data, fa}, fa = fa + 1 (wraps modulo 2^AW). Continue in REQ with the new address if count-after-update < DEPTH; otherwise drop mem_req and go to IDLE. Back-to-back requests allowed.
    - On mem_ack with pc_load in the same cycle: discard the data, fa = pc_in, go to IDLE.
    - On pc_load without mem_ack: fa = pc_in, go to DISCARD.
  - DISCARD: keep mem_req high with the old address until mem_ack. Drop the data; mem_req falls the next cycle; go to IDLE. Further pc_load in DISCARD only updates fa.
- Only one outstanding request at a time. Space check uses post-pop count, so a simultaneous pop frees a slot in the same cycle.
- Pop: ir_valid && ir_take advances the read pointer and decrements count. ir_take with ir_valid = 0 is ignored.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- pc_load has priority over push and pop in the same cycle: count = 0, pointers = 0, ir_valid = 0 next cycle.
- Latency, empty queue:
  - pc_load at cycle N → mem_req high at N+1 with mem_addr = pc_in.
  - mem_ack at cycle M → ir_valid high at M+1.
- Full: count = DEPTH means no request issued; ir_take on a full queue lets fetching resume next cycle.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset then pc_load with pc_in = 0o001000; memory acks after 1 cycle with data 0o201040_000123 → mem_addr = 0o001000. Next cycle ir_valid = 1, ir_word[0:8] = 0o201, ir_word[9:12] = 0o01, ir_addr = 0o001000. Next request uses address 0o001001.
- ir_take held low, memory always acks → exactly 4 words queued (addresses n..n+3). mem_req stays 0 with count = 4. One ir_take → mem_req reasserts next cycle with address n+4.
- pc_load(0o002000) while a request for 0o001002 is outstanding; ack 3 cycles later → data for 0o001002 never appears. mem_addr stays 0o001002 until ack, then next request is 0o002000. First queued ir_addr = 0o002000.
- pc_load and mem_ack in the same cycle → acked data dropped, count = 0. Next request is to pc_in.
- fa = 0o777777, ack → entry address 0o777777, next mem_addr = 0o000000.
- rst low mid-request with count = 3 → next cycle mem_req = 0, ir_valid = 0, count = 0. A late mem_ack after reset is ignored.
